// File: rtl/serial_pattern_generator.sv
`default_nettype none
// ============================================================================
// Module   : serial_pattern_generator
// Purpose  : Shifts a captured pattern out MSB first, repeated with zero gaps.
// Revision : 1.0 - initial release
// ============================================================================
module serial_pattern_generator #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             en,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] rep_cnt,
    input  logic [CNT_W-1:0] gap_len,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    localparam int BI_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
    localparam logic [BI_W-1:0]  c_BIT_MSB = BI_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             r_state,     w_state_nx;
    logic [PAT_W-1:0]   r_pat,       w_pat_nx;
    logic [PAT_W-1:0]   r_shreg,     w_shreg_nx;
    logic [BI_W-1:0]    r_bit_idx,   w_bit_idx_nx;
    logic [CNT_W-1:0]   r_reps_left, w_reps_left_nx;
    logic [CNT_W-1:0]   r_gap_ld,    w_gap_ld_nx;
    logic [CNT_W-1:0]   r_gap_cnt,   w_gap_cnt_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pat       <= '0;
            r_shreg     <= '0;
            r_bit_idx   <= '0;
            r_reps_left <= '0;
            r_gap_ld    <= '0;
            r_gap_cnt   <= '0;
        end else if (en) begin
            r_state     <= w_state_nx;
            r_pat       <= w_pat_nx;
            r_shreg     <= w_shreg_nx;
            r_bit_idx   <= w_bit_idx_nx;
            r_reps_left <= w_reps_left_nx;
            r_gap_ld    <= w_gap_ld_nx;
            r_gap_cnt   <= w_gap_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_pat_nx       = r_pat;
        w_shreg_nx     = r_shreg;
        w_bit_idx_nx   = r_bit_idx;
        w_reps_left_nx = r_reps_left;
        w_gap_ld_nx    = r_gap_ld;
        w_gap_cnt_nx   = r_gap_cnt;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_pat_nx       = pattern;
                    w_shreg_nx     = pattern;
                    w_bit_idx_nx   = c_BIT_MSB;
                    w_reps_left_nx = (rep_cnt == '0) ? c_ONE : rep_cnt;
                    w_gap_ld_nx    = gap_len;
                    w_state_nx     = SHIFT;
                end
            end
            SHIFT: begin
                w_shreg_nx   = r_shreg << 1;
                w_bit_idx_nx = r_bit_idx - 1'b1;
                if (r_bit_idx == '0) begin
                    if (r_reps_left == c_ONE) begin
                        w_state_nx = DONE;
                    end else if (r_gap_ld == '0) begin
                        // Back-to-back repetition: reload without a bubble.
                        w_shreg_nx     = r_pat;
                        w_bit_idx_nx   = c_BIT_MSB;
                        w_reps_left_nx = r_reps_left - c_ONE;
                    end else begin
                        w_gap_cnt_nx   = r_gap_ld;
                        w_reps_left_nx = r_reps_left - c_ONE;
                        w_state_nx     = GAP;
                    end
                end
            end
            GAP: begin
                w_gap_cnt_nx = r_gap_cnt - c_ONE;
                if (r_gap_cnt == c_ONE) begin
                    w_shreg_nx   = r_pat;
                    w_bit_idx_nx = c_BIT_MSB;
                    w_state_nx   = SHIFT;
                end
            end
            DONE: begin
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    assign x       = (r_state == SHIFT) ? r_shreg[PAT_W-1] : 1'b0;
    assign x_valid = (r_state == SHIFT) || (r_state == GAP);
    assign busy    = (r_state != IDLE);
    assign done    = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_serial_pattern_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_pattern_generator
// Purpose  : Randomized and directed check of serial_pattern_generator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_pattern_generator;

    localparam int PAT_W = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             en;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] rep_cnt;
    logic [CNT_W-1:0] gap_len;
    logic             x;
    logic             x_valid;
    logic             busy;
    logic             done;

    int n_chk = 0;
    int n_bad = 0;
    int n_bursts = 0;

    // Expected output per enabled cycle, packed as {x, x_valid, busy, done}.
    logic [3:0] q_exp[$];

    serial_pattern_generator #(.PAT_W(PAT_W), .CNT_W(CNT_W)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .en      (en),
        .pattern (pattern),
        .rep_cnt (rep_cnt),
        .gap_len (gap_len),
        .x       (x),
        .x_valid (x_valid),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // Whole burst written out as the stream a detector would see.
    task automatic push_burst(input logic [PAT_W-1:0] p, input int r, input int g);
        int reps;
        reps = (r == 0) ? 1 : r;
        for (int k = 0; k < reps; k++) begin
            for (int b = PAT_W - 1; b >= 0; b--) q_exp.push_back({p[b], 3'b110});
            if (k < reps - 1)
                for (int z = 0; z < g; z++) q_exp.push_back(4'b0110);
        end
        q_exp.push_back(4'b0011);
        n_bursts++;
    endtask

    task automatic check_outputs(input string tag);
        logic [3:0] e;
        e = (q_exp.size() == 0) ? 4'b0000 : q_exp[0];
        chk({tag, ".x"},     {31'd0, x},       {31'd0, e[3]});
        chk({tag, ".valid"}, {31'd0, x_valid}, {31'd0, e[2]});
        chk({tag, ".busy"},  {31'd0, busy},    {31'd0, e[1]});
        chk({tag, ".done"},  {31'd0, done},    {31'd0, e[0]});
    endtask

    task automatic step(input logic s, input logic e, input logic [PAT_W-1:0] p,
                        input logic [CNT_W-1:0] r, input logic [CNT_W-1:0] g,
                        input string tag);
        @(negedge clk);
        start = s; en = e; pattern = p; rep_cnt = r; gap_len = g;
        @(posedge clk);
        if (en) begin
            if (q_exp.size() != 0) void'(q_exp.pop_front());
            else if (start)        push_burst(pattern, int'(rep_cnt), int'(gap_len));
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic idle_until_quiet(input string tag);
        for (int i = 0; i < 400 && q_exp.size() != 0; i++)
            step(1'b0, 1'b1, 4'hF, 4'hF, 4'hF, tag);
        chk({tag, ".drain"}, q_exp.size(), 0);
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        q_exp.delete();
        check_outputs(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; en = 1'b0;
        pattern = '0; rep_cnt = '0; gap_len = '0;
        #12;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Reset after two pattern bits, then a fresh start from the MSB.
        step(1'b1, 1'b1, 4'b1011, 4'd2, 4'd1, "rst_mid.start");
        step(1'b0, 1'b1, 4'b0000, 4'd0, 4'd0, "rst_mid.b0");
        step(1'b0, 1'b1, 4'b0000, 4'd0, 4'd0, "rst_mid.b1");
        async_reset("rst_mid.async");
        step(1'b0, 1'b1, 4'b0000, 4'd0, 4'd0, "rst_mid.after");
        step(1'b1, 1'b1, 4'b1000, 4'd1, 4'd0, "rst_mid.restart");
        idle_until_quiet("rst_mid.tail");

        // Back-to-back repetitions, then repetitions with gaps.
        step(1'b1, 1'b1, 4'b0101, 4'd3, 4'd0, "b2b");
        idle_until_quiet("b2b");
        step(1'b1, 1'b1, 4'b1101, 4'd2, 4'd2, "gap");
        idle_until_quiet("gap");

        // rep_cnt of zero behaves as a single repetition.
        step(1'b1, 1'b1, 4'b1100, 4'd0, 4'd3, "rep0");
        idle_until_quiet("rep0");

        // Stalls mid-pattern hold the current bit.
        step(1'b1, 1'b1, 4'b1011, 4'd1, 4'd0, "stall.start");
        for (int i = 0; i < 12; i++)
            step(1'b0, (i % 3) != 1, 4'b0000, 4'd0, 4'd0, "stall");
        idle_until_quiet("stall");

        // start with en low is not taken.
        step(1'b1, 1'b0, 4'b1111, 4'd1, 4'd0, "en0_start");
        step(1'b0, 1'b1, 4'b1111, 4'd1, 4'd0, "en0_after");

        // Mid-burst start ignored; held start relaunches one cycle after done.
        step(1'b1, 1'b1, 4'b1001, 4'd2, 4'd1, "held");
        for (int i = 0; i < 20; i++)
            step(1'b1, 1'b1, 4'($urandom), 4'($urandom), 4'($urandom), "held");
        chk("held.bursts", n_bursts >= 8, 1);
        idle_until_quiet("held.tail");

        // All-ones counts: exact length, no wrap.
        step(1'b1, 1'b1, 4'b1110, 4'hF, 4'hF, "max");
        idle_until_quiet("max");

        // Randomized traffic with occasional asynchronous reset.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) async_reset("rand.rst");
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                 4'($urandom),
                 ($urandom_range(0, 15) == 0) ? 4'hF : 4'($urandom_range(0, 4)),
                 ($urandom_range(0, 15) == 0) ? 4'hF : 4'($urandom_range(0, 3)),
                 "rand");
        end
        idle_until_quiet("rand.tail");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_pattern_generator.md
Name: serial_pattern_generator

Overview:
- Serial bit-stream source that produces the input side for the team's serial sequence detectors.
- Loads a PAT_W-bit pattern and shifts it out MSB first, one bit per enabled clock.
- Repeats the pattern a programmable number of times, with a programmable run of zero "gap" bits between repetitions.
- Intended as a stimulus engine feeding a detector's single-bit x input, in bench and on-chip self-test.

Parameters:
- PAT_W, 4, pattern width in bits (>=2).
- CNT_W, 4, width of the repeat-count and gap-length fields.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new burst; sampled only in IDLE.
- en  input  1  clock enable / advance; 0 freezes all state and outputs.
- pattern  input  PAT_W  pattern to transmit, MSB sent first; captured at start.
- rep_cnt  input  CNT_W  number of pattern repetitions; 0 is treated as 1; captured at start.
- gap_len  input  CNT_W  zero bits inserted between repetitions, none after the last; captured at start.
- x  output  1  serial data bit.
- x_valid  output  1  x carries a stream bit (pattern or gap).
- busy  output  1  burst in progress (state != IDLE).
- done  output  1  single-cycle pulse when a burst completes.

Behaviour:
- One clock domain: clk. Reset is asynchronous, active-high on rst.
- Reset values:
  - state = IDLE.
  - x = 0, x_valid = 0, busy = 0, done = 0.
  - Shift register, bit counter, repetition counter and gap counter all cleared.
- FSM states: IDLE, SHIFT, GAP, DONE. All transitions require en=1; with en=0 every register holds, including done.
- IDLE:
  - x=0, x_valid=0.
  - On start=1 at an enabled edge: capture pattern into the shift register; bit_idx=PAT_W-1; reps_left=max(rep_cnt,1); gap_ld=gap_len; go to SHIFT.
- SHIFT:
  - x = shreg[PAT_W-1], x_valid = 1.
  - Each enabled edge shifts the register left by 1 and decrements bit_idx.
  - When bit_idx==0 at the edge:
    - reps_left==1 -> DONE.
    - else if gap_ld==0 -> reload the pattern, decrement reps_left, stay in SHIFT (back-to-back, no bubble).
    - else -> GAP with gap counter = gap_ld, decrement reps_left.
- GAP:
  - x=0, x_valid=1.
  - Decrement the counter each enabled edge.
  - At counter==1: reload the pattern, bit_idx=PAT_W-1, go to SHIFT.
- DONE:
  - x=0, x_valid=0, done=1 for exactly one enabled cycle.
  - Go to IDLE on the next enabled edge.
- busy = 1 in SHIFT, GAP and DONE.
- Latency:
  - First pattern bit is on x in the cycle after the start edge.
  - A burst occupies exactly R*PAT_W + (R-1)*G x_valid cycles, where R=max(rep_cnt,1) and G=gap_len, followed by one DONE cycle.
- x and x_valid derive only from registers; no combinational path from any input to any output.
- Boundary rules:
  - start while busy -> ignored; captured fields are never changed mid-burst.
  - start held high continuously -> new burst begins at the first enabled IDLE edge, i.e. one cycle after done.
  - start=1 with en=0 -> not accepted.
  - rep_cnt=0 -> identical to rep_cnt=1.
  - rep_cnt or gap_len at all ones -> counters do not wrap; exact count emitted.
  - Pattern input changing after capture -> no effect.
  - rst asserted mid-burst -> immediate IDLE, outputs cleared; no done pulse.
  - en deasserted mid-pattern -> x holds its current bit, x_valid holds, counters frozen; resumes at the same bit.

Test Plan:
- Reset during SHIFT after 2 bits -> x=0, x_valid=0, busy=0 immediately; no done; next start restarts from the MSB.
- PAT_W=3, pattern=3'b101, rep_cnt=3, gap_len=0 -> x_valid high 9 cycles, x = 1,0,1,1,0,1,1,0,1; done pulses once in cycle 10. A downstream overlapping 101 detector flags 3 hits.
- pattern=3'b101, rep_cnt=2, gap_len=2 -> x = 1,0,1,0,0,1,0,1 (8 valid cycles), then done; busy high for 9 cycles.
- PAT_W=4, pattern=4'b1100, rep_cnt=0 -> exactly 4 valid bits 1,1,0,0 and one done pulse, same as rep_cnt=1.
- en toggled 1,0,0,1 every other cycle during pattern 4'b1011 -> each bit held while en=0; sequence 1,0,1,1 preserved; total burst stretched by the stalled cycles.
- start pulsed mid-burst with a different pattern, and start held high across done -> mid-burst pulse ignored and output unchanged; held start launches a second burst one cycle after done.
